// File: rtl/collision_judge.sv
// Per-frame sprite overlap detector driving the enemy explosion, score, lives and game-over.
// A commit on the last active pixel raises boom and the hit pulses on the following clk.
module collision_judge #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int BOOM_TICKS = 15,
  parameter int LIVES      = 3,
  parameter int SCORE_W    = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               move_tick,
  input  logic               enemy_en,
  input  logic               bullet_en,
  input  logic               player_en,
  input  logic               enemyplane_exist,
  output logic               boom,
  output logic               bullet_hit,
  output logic               player_hit,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic               game_over
);

  localparam int              CNT_W        = $clog2(BOOM_TICKS + 1);
  localparam logic [9:0]       LP_X_LAST    = 10'(H_ACTIVE - 1);
  localparam logic [9:0]       LP_Y_LAST    = 10'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] LP_TICK_LAST = CNT_W'(BOOM_TICKS - 1);

  typedef enum logic [1:0] {
    ST_ALIVE   = 2'd0,
    ST_BOOM    = 2'd1,
    ST_RECOVER = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_hit_f;
  logic               r_crash_f;
  logic [CNT_W-1:0]   r_cnt;
  logic [SCORE_W-1:0] r_score;
  logic [1:0]         r_lives;
  logic               r_bullet_hit;
  logic               r_player_hit;

  logic w_active;
  logic w_commit;
  logic w_hit;
  logic w_crash;
  logic w_fire;

  assign w_active = (x <= LP_X_LAST) && (y <= LP_Y_LAST);
  assign w_commit = (x == LP_X_LAST) && (y == LP_Y_LAST);
  // Fold in the current pixel so an overlap on the commit pixel itself still counts.
  assign w_hit    = r_hit_f   | (w_active & enemy_en & bullet_en);
  assign w_crash  = r_crash_f | (w_active & enemy_en & player_en);

  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    case (r_state)
      ST_ALIVE: begin
        if (w_commit && enemyplane_exist && (w_hit || w_crash)) begin
          w_state_nxt = ST_BOOM;
          w_fire      = 1'b1;
        end
      end
      ST_BOOM: begin
        if (move_tick && (r_cnt == LP_TICK_LAST)) begin
          w_state_nxt = (r_lives == 2'd0) ? ST_OVER : ST_RECOVER;
        end
      end
      // The respawn frame can carry stale overlap, so its commit is thrown away.
      ST_RECOVER: begin
        if (w_commit) begin
          w_state_nxt = ST_ALIVE;
        end
      end
      ST_OVER: begin
        w_state_nxt = ST_OVER;
      end
      default: begin
        w_state_nxt = ST_ALIVE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_ALIVE;
      r_hit_f      <= 1'b0;
      r_crash_f    <= 1'b0;
      r_cnt        <= '0;
      r_score      <= '0;
      r_lives      <= 2'(LIVES);
      r_bullet_hit <= 1'b0;
      r_player_hit <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hit_f      <= w_commit ? 1'b0 : w_hit;
      r_crash_f    <= w_commit ? 1'b0 : w_crash;
      r_bullet_hit <= w_fire & w_hit;
      r_player_hit <= w_fire & w_crash;
      if (w_fire && w_hit && (r_score != '1)) begin
        r_score <= r_score + 1'b1;
      end
      if (w_fire && w_crash && (r_lives != 2'd0)) begin
        r_lives <= r_lives - 2'd1;
      end
      if (w_fire) begin
        r_cnt <= '0;
      end else if ((r_state == ST_BOOM) && move_tick) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign boom       = (r_state == ST_BOOM);
  assign game_over  = (r_state == ST_OVER);
  assign bullet_hit = r_bullet_hit;
  assign player_hit = r_player_hit;
  assign score      = r_score;
  assign lives      = r_lives;

endmodule

// File: tb/tb_collision_judge.sv
// Directed bench for collision_judge; expected outputs come from a small state model via a scoreboard queue.
module tb_collision_judge;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] x, y;
  logic       move_tick, enemy_en, bullet_en, player_en, enemyplane_exist;
  logic       boom, bullet_hit, player_hit, game_over;
  logic [9:0] score;
  logic [1:0] lives;

  collision_judge dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .move_tick(move_tick),
    .enemy_en(enemy_en), .bullet_en(bullet_en), .player_en(player_en),
    .enemyplane_exist(enemyplane_exist), .boom(boom), .bullet_hit(bullet_hit),
    .player_hit(player_hit), .score(score), .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // {boom, bullet_hit, player_hit, game_over, lives, score}
  typedef logic [15:0] exp_t;
  exp_t q[$];

  int total = 0;
  int bad   = 0;

  // model: 0 ALIVE, 1 BOOM, 2 RECOVER, 3 OVER
  int         m_st;
  int         m_cnt;
  logic [9:0] m_sc;
  logic [1:0] m_lv;

  function automatic exp_t mk(input logic bh, input logic ph);
    return {(m_st == 1), bh, ph, (m_st == 3), m_lv, m_sc};
  endfunction

  function automatic exp_t obs();
    return {boom, bullet_hit, player_hit, game_over, lives, score};
  endfunction

  task automatic model_reset();
    m_st  = 0;
    m_cnt = 0;
    m_sc  = 10'd0;
    m_lv  = 2'd3;
  endtask

  task automatic chk(input string tag, input exp_t o, input exp_t e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic clk_chk(input string tag, input exp_t e);
    exp_t got;
    q.push_back(e);
    @(posedge clk);
    #1;
    got = q.pop_front();
    chk(tag, obs(), got);
  endtask

  task automatic idle();
    x = 10'd700; y = 10'd0;
    enemy_en = 1'b0; bullet_en = 1'b0; player_en = 1'b0; move_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      idle();
      move_tick = 1'b1;
      if (m_st == 1) begin
        m_cnt++;
        if (m_cnt == 15) m_st = (m_lv == 2'd0) ? 3 : 2;
      end
      clk_chk("tick", mk(1'b0, 1'b0));
      move_tick = 1'b0;
      clk_chk("tick_gap", mk(1'b0, 1'b0));
    end
  endtask

  task automatic frame(input logic [9:0] px, input logic [9:0] py,
                       input logic e, input logic b, input logic p, input logic ex);
    logic act, hit, crash, bh, ph;
    act   = (px < 10'd640) && (py < 10'd480);
    hit   = act && e && b;
    crash = act && e && p;
    bh = 1'b0; ph = 1'b0;
    idle();
    enemyplane_exist = ex;
    x = px; y = py; enemy_en = e; bullet_en = b; player_en = p;
    if (!(px == 10'd639 && py == 10'd479)) begin
      clk_chk("overlap_px", mk(1'b0, 1'b0));
      idle();
      x = 10'd639; y = 10'd479;
    end
    if (m_st == 0 && ex && (hit || crash)) begin
      bh = hit; ph = crash;
      if (hit && m_sc != 10'h3ff) m_sc = m_sc + 10'd1;
      if (crash && m_lv != 2'd0) m_lv = m_lv - 2'd1;
      m_st = 1; m_cnt = 0;
    end else if (m_st == 2) begin
      m_st = 0;
    end
    clk_chk("commit", mk(bh, ph));
    idle();
    clk_chk("after_commit", mk(1'b0, 1'b0));
    enemyplane_exist = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    enemyplane_exist = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", obs(), mk(1'b0, 1'b0));
    rst = 1'b0;
    clk_chk("post_reset", mk(1'b0, 1'b0));

    // bullet hit, commit ignored mid-explosion, then RECOVER discards a frame
    frame(10'd100, 10'd50, 1'b1, 1'b1, 1'b0, 1'b1);
    ticks(5);
    frame(10'd100, 10'd50, 1'b1, 1'b1, 1'b0, 1'b1);
    ticks(10);
    frame(10'd100, 10'd50, 1'b1, 1'b1, 1'b0, 1'b1);
    frame(10'd100, 10'd50, 1'b1, 1'b1, 1'b0, 1'b1);
    ticks(15);
    frame(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // bullet and player in one frame
    frame(10'd320, 10'd240, 1'b1, 1'b1, 1'b1, 1'b1);
    ticks(15);
    frame(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // overlap only on the commit pixel
    frame(10'd639, 10'd479, 1'b1, 1'b1, 1'b0, 1'b1);
    ticks(15);
    frame(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // blanking overlaps and absent enemy
    frame(10'd700, 10'd50, 1'b1, 1'b1, 1'b1, 1'b1);
    frame(10'd100, 10'd500, 1'b1, 1'b1, 1'b1, 1'b1);
    frame(10'd100, 10'd50, 1'b1, 1'b1, 1'b1, 1'b0);

    // two more crashes take lives to 0, then game over
    frame(10'd200, 10'd100, 1'b1, 1'b0, 1'b1, 1'b1);
    ticks(15);
    frame(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    frame(10'd200, 10'd100, 1'b1, 1'b0, 1'b1, 1'b1);
    ticks(15);
    frame(10'd100, 10'd50, 1'b1, 1'b1, 1'b1, 1'b1);
    frame(10'd100, 10'd50, 1'b1, 1'b1, 1'b1, 1'b1);
    ticks(2);

    // async reset in the middle of an explosion
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_from_over", obs(), mk(1'b0, 1'b0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    frame(10'd100, 10'd50, 1'b1, 1'b1, 1'b0, 1'b1);
    ticks(7);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_mid_boom", obs(), mk(1'b0, 1'b0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    clk_chk("rst_release", mk(1'b0, 1'b0));
    frame(10'd100, 10'd50, 1'b1, 1'b1, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
